// File: rtl/wb_port_arbiter.sv
// Two-port register-file writeback arbiter: pipeline port A has priority, the
// long-latency port B is protected by a starvation counter and a pending-write mask.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic [31:0] busy,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);

    // Counter must hold STARVE_LIMIT; never narrower than 2 bits.
    localparam int CW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int CW     = (CW_RAW < 2) ? 2 : CW_RAW;
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;
    logic [31:0]   r_busy;
    logic          r_we3;
    logic [4:0]    r_wa3;
    logic [31:0]   r_wd3;

    logic          w_a_blocked;
    logic          w_force_b;
    logic          w_grant_a;
    logic          w_grant_b;
    logic [4:0]    w_wr_addr;
    logic [31:0]   w_wr_data;
    logic          w_wr_en;
    logic [31:0]   w_busy_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign w_a_blocked = (a_addr != 5'd0) && r_busy[a_addr];
    assign w_force_b   = b_valid && (r_starve_cnt >= CNT_LIMIT);

    assign a_ready = a_valid && !w_a_blocked && !w_force_b;
    assign b_ready = b_valid && (w_force_b || !a_valid || w_a_blocked);

    assign w_grant_a = a_valid && a_ready;
    assign w_grant_b = b_valid && b_ready;

    // Grants are mutually exclusive, so a simple mux selects the winner.
    always_comb begin
        w_wr_addr = a_addr;
        w_wr_data = a_data;
        if (w_grant_b) begin
            w_wr_addr = b_addr;
            w_wr_data = b_data;
        end
    end

    // Writes to r0 are accepted but discarded.
    assign w_wr_en = (w_grant_a || w_grant_b) && (w_wr_addr != 5'd0);

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant_b)
            w_busy_nxt[b_addr] = 1'b0;
        if (issue_valid && (issue_addr != 5'd0))
            w_busy_nxt[issue_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = r_starve_cnt;
        if (w_grant_b)
            w_cnt_nxt = '0;
        else if (b_valid && (r_starve_cnt != CNT_MAX))
            w_cnt_nxt = r_starve_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_starve_cnt <= '0;
            r_busy       <= '0;
            r_we3        <= 1'b0;
            r_wa3        <= '0;
            r_wd3        <= '0;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_we3        <= w_wr_en;
            if (w_wr_en) begin
                r_wa3 <= w_wr_addr;
                r_wd3 <= w_wr_data;
            end
        end
    end

    assign busy = r_busy;
    assign we3  = r_we3;
    assign wa3  = r_wa3;
    assign wd3  = r_wd3;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: per-cycle table plus reset sequences.
module tb_wb_port_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_addr, b_addr, issue_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [31:0] busy;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .busy(busy), .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        bv; logic [4:0] ba; logic [31:0] bd;
        logic        iv; logic [4:0] ia;
        logic        ar; logic br;
        logic        we; logic [4:0] wa; logic [31:0] wd; logic [31:0] bz;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        issue_valid = v.iv; issue_addr = v.ia;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        issue_valid = 0; issue_addr = 0;
    endtask

    function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                                logic bv, logic [4:0] ba, logic [31:0] bd,
                                logic iv, logic [4:0] ia, logic ar, logic br,
                                logic we, logic [4:0] wa, logic [31:0] wd, logic [31:0] bz);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.iv = iv; v.ia = ia; v.ar = ar; v.br = br;
        v.we = we; v.wa = wa; v.wd = wd; v.bz = bz;
        return v;
    endfunction

    initial begin
        //            av aa  ad            bv ba bd      iv ia  ar br  we wa  wd            busy
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0,  1, 0,  1, 5, 32'hDEADBEEF, 0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,      0, 0,  0, 0,  0, 5, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 1, 32'h11,       1, 7, 32'h77, 0, 0,  1, 0,  1, 1, 32'h11, 0);
        vecs[3]  = mk(1, 1, 32'h12,       1, 7, 32'h77, 0, 0,  1, 0,  1, 1, 32'h12, 0);
        vecs[4]  = mk(1, 1, 32'h13,       1, 7, 32'h77, 0, 0,  1, 0,  1, 1, 32'h13, 0);
        vecs[5]  = mk(1, 1, 32'h14,       1, 7, 32'h77, 0, 0,  0, 1,  1, 7, 32'h77, 0);
        vecs[6]  = mk(1, 1, 32'h15,       1, 7, 32'h78, 0, 0,  1, 0,  1, 1, 32'h15, 0);
        vecs[7]  = mk(0, 0, 0,            0, 0, 0,      0, 0,  0, 0,  0, 1, 32'h15, 0);
        vecs[8]  = mk(0, 0, 0,            1, 2, 32'h22, 0, 0,  0, 1,  1, 2, 32'h22, 0);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,      1, 9,  0, 0,  0, 2, 32'h22, 32'h200);
        vecs[10] = mk(1, 9, 32'hA9,       1, 9, 32'hB9, 0, 0,  0, 1,  1, 9, 32'hB9, 0);
        vecs[11] = mk(1, 9, 32'hA9,       0, 0, 0,      0, 0,  1, 0,  1, 9, 32'hA9, 0);
        vecs[12] = mk(1, 0, 32'h55,       0, 0, 0,      0, 0,  1, 0,  0, 9, 32'hA9, 0);
        vecs[13] = mk(0, 0, 0,            0, 0, 0,      1, 0,  0, 0,  0, 9, 32'hA9, 0);
        vecs[14] = mk(0, 0, 0,            0, 0, 0,      1, 3,  0, 0,  0, 9, 32'hA9, 32'h8);
        vecs[15] = mk(0, 0, 0,            1, 3, 32'h33, 1, 3,  0, 1,  1, 3, 32'h33, 32'h8);
        vecs[16] = mk(1, 3, 32'h44,       0, 0, 0,      0, 0,  0, 0,  0, 3, 32'h33, 32'h8);
        vecs[17] = mk(1, 3, 32'h44,       1, 3, 32'h34, 0, 0,  0, 1,  1, 3, 32'h34, 0);
        vecs[18] = mk(1, 3, 32'h45,       0, 0, 0,      0, 0,  1, 0,  1, 3, 32'h45, 0);

        idle_inputs();
        RST_N = 1'b0;
        #2;
        chk("reset_we3", {31'd0, we3}, 0);
        chk("reset_wa3", {27'd0, wa3}, 0);
        chk("reset_wd3", wd3, 0);
        chk("reset_busy", busy, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ar});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].br});
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_we3", i), {31'd0, we3}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_wa3", i), {27'd0, wa3}, {27'd0, vecs[i].wa});
            chk($sformatf("v%0d_wd3", i), wd3, vecs[i].wd);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].bz);
        end

        // Mid-stream async reset: build up starvation and a pending bit, then reset between edges.
        @(negedge CLK);
        a_valid = 1; a_addr = 1; a_data = 32'h66;
        b_valid = 1; b_addr = 7; b_data = 32'h99;
        issue_valid = 1; issue_addr = 4;
        @(posedge CLK);
        #1;
        issue_valid = 0;
        chk("pre_rst_busy", busy, 32'h10);
        chk("pre_rst_we3", {31'd0, we3}, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_we3", {31'd0, we3}, 0);
        chk("arst_wa3", {27'd0, wa3}, 0);
        chk("arst_wd3", wd3, 0);
        chk("arst_busy", busy, 0);
        chk("arst_starve", 32'(dut.r_starve_cnt), 0);
        @(posedge CLK);
        #1;
        chk("in_rst_we3", {31'd0, we3}, 0);
        idle_inputs();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rel_we3", {31'd0, we3}, 0);
        chk("post_rel_wa3", {27'd0, wa3}, 0);

        // Contention right after reset: counter restarted, so A wins three cycles again.
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            a_valid = 1; a_addr = 6; a_data = 32'h600 + c;
            b_valid = 1; b_addr = 8; b_data = 32'h800;
            #1;
            chk($sformatf("post_rst_c%0d_a_ready", c), {31'd0, a_ready}, (c < 3) ? 1 : 0);
            @(posedge CLK);
            #1;
            chk($sformatf("post_rst_c%0d_wa3", c), {27'd0, wa3}, (c < 3) ? 6 : 8);
        end

        idle_inputs();
        @(posedge CLK);
        #1;
        chk("final_idle_we3", {31'd0, we3}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
